// File: rtl/mem_c_tile_addr_gen.sv
// C-tile write address generator: walks an m x p result matrix tile by tile and
// issues one bus write per LANES-wide beat. MEM_C_PARTIAL_TILE_EN enables ragged edge tiles.
module mem_c_tile_addr_gen #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DIM_WIDTH        = 16,
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ARRAY_HEIGHT     = 4,
  parameter int ARRAY_WIDTH      = 32,
  localparam int LANES           = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  m,
  input  logic [DIM_WIDTH-1:0]  p,
  input  logic [DIM_WIDTH-1:0]  ld_c,
  input  logic [ADDR_WIDTH-1:0] base_addr_c,
  output logic                  do_tran,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LANES-1:0]      lane_mask,
  input  logic                  tran_done,
  input  logic                  fifo_empty,
  output logic                  fifo_incr,
  output logic                  busy,
  output logic                  op_done,
  output logic                  cfg_err
);

  // state       | meaning
  // IDLE        | waiting for start_i
  // WAIT_DATA   | waiting for the C buffer to hold the next beat
  // WRITE_DATA  | bus write in flight, do_tran held until tran_done
  // UPDATE_ADDR | pop the buffer, advance to the next beat or finish
  typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE_DATA, UPDATE_ADDR} state_t;

  localparam int LOG2_DWB = $clog2(DATA_WIDTH_BYTES);
  localparam int RW       = $clog2(ARRAY_HEIGHT) + 1;
  localparam int CW       = $clog2(ARRAY_WIDTH) + 1;
  localparam int XW       = DIM_WIDTH + 1;
  localparam int MW       = XW + 1;
  localparam int PW       = 2 * DIM_WIDTH + 1;
  localparam int OFFW     = PW + 2 + LOG2_DWB;
  localparam int SW       = (OFFW > ADDR_WIDTH) ? OFFW : ADDR_WIDTH;

  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]  m_q, p_q, ld_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [XW-1:0]         col_q, col_d, row_q, row_d;
  logic                  do_tran_d, op_done_d, cfg_err_d, latch_cfg;

  logic [XW-1:0]         row_idx, col_idx;
  logic [PW-1:0]         prod;
  logic [OFFW-1:0]       elem, byte_off;
  logic [SW-1:0]         sum;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LANES-1:0]      mask_d;
  logic                  skip, dim_err, cfg_bad;
  logic                  r_last, c_last, col_last, row_last;

  // Address datapath is kept wide until the final modulo-2^ADDR_WIDTH add.
  always_comb begin
    row_idx  = row_q + XW'(r_q);
    col_idx  = col_q + XW'(c_q);
    prod     = PW'(row_idx) * PW'(ld_q);
    elem     = OFFW'(prod) + OFFW'(col_idx);
    byte_off = elem << LOG2_DWB;
    sum      = SW'(base_q) + SW'(byte_off);
    addr_d   = ADDR_WIDTH'(sum);
  end

`ifdef MEM_C_PARTIAL_TILE_EN
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_d[i] = (MW'(col_idx) + MW'(i)) < MW'(p_q);
    end
  end
  assign skip    = (row_idx >= XW'(m_q)) || (mask_d == '0);
  assign dim_err = 1'b0;
`else
  assign mask_d  = '1;
  assign skip    = 1'b0;
  assign dim_err = ((m % DIM_WIDTH'(ARRAY_HEIGHT)) != '0) ||
                   ((p % DIM_WIDTH'(ARRAY_WIDTH)) != '0);
`endif

  assign cfg_bad  = (m == '0) || (p == '0) || (ld_c < p) || dim_err;

  assign r_last   = (r_q == RW'(ARRAY_HEIGHT - 1));
  assign c_last   = (c_q == CW'(ARRAY_WIDTH - LANES));
  assign col_last = ((col_q + XW'(ARRAY_WIDTH)) >= XW'(p_q));
  assign row_last = ((row_q + XW'(ARRAY_HEIGHT)) >= XW'(m_q));

  always_comb begin
    state_d   = state_q;
    do_tran_d = do_tran;
    op_done_d = 1'b0;
    cfg_err_d = 1'b0;
    latch_cfg = 1'b0;
    r_d       = r_q;
    c_d       = c_q;
    col_d     = col_q;
    row_d     = row_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_bad) begin
            op_done_d = 1'b1;
            cfg_err_d = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            r_d       = '0;
            c_d       = '0;
            col_d     = '0;
            row_d     = '0;
            state_d   = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (!fifo_empty) state_d = skip ? UPDATE_ADDR : WRITE_DATA;
      end
      WRITE_DATA: begin
        if (!do_tran) begin
          do_tran_d = 1'b1;
        end else if (tran_done) begin
          do_tran_d = 1'b0;
          state_d   = UPDATE_ADDR;
        end
      end
      UPDATE_ADDR: begin
        state_d = WAIT_DATA;
        // Row within tile is innermost, then lane chunk, tile column, tile row.
        if (!r_last) begin
          r_d = r_q + RW'(1);
        end else begin
          r_d = '0;
          if (!c_last) begin
            c_d = c_q + CW'(LANES);
          end else begin
            c_d = '0;
            if (!col_last) begin
              col_d = col_q + XW'(ARRAY_WIDTH);
            end else begin
              col_d = '0;
              if (!row_last) begin
                row_d = row_q + XW'(ARRAY_HEIGHT);
              end else begin
                state_d   = IDLE;
                op_done_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      do_tran   <= 1'b0;
      op_done   <= 1'b0;
      cfg_err   <= 1'b0;
      addr      <= '0;
      lane_mask <= '1;
      r_q       <= '0;
      c_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      m_q       <= '0;
      p_q       <= '0;
      ld_q      <= '0;
      base_q    <= '0;
    end else begin
      state_q <= state_d;
      do_tran <= do_tran_d;
      op_done <= op_done_d;
      cfg_err <= cfg_err_d;
      r_q     <= r_d;
      c_q     <= c_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (latch_cfg) begin
        m_q    <= m;
        p_q    <= p;
        ld_q   <= ld_c;
        base_q <= base_addr_c;
      end
      // Counters are stable in WAIT_DATA, so addr is frozen for the whole write.
      if (state_q == WAIT_DATA) begin
        addr      <= addr_d;
        lane_mask <= mask_d;
      end
    end
  end

  assign fifo_incr = (state_q == UPDATE_ADDR);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_c_tile_addr_gen.sv
// Bench for mem_c_tile_addr_gen: vector table plus reset and stall sequences,
// writes checked against a queue filled by a traversal model.
module tb_mem_c_tile_addr_gen;
  localparam int L  = 16;
  localparam int AH = 4;
  localparam int AW = 32;
  localparam int DB = 2;

  logic        clk = 0;
  logic        reset = 1;
  logic        start_i = 0;
  logic [15:0] m = 0, p = 0, ld_c = 0;
  logic [31:0] base_addr_c = 0;
  logic        do_tran;
  logic [31:0] addr;
  logic [15:0] lane_mask;
  logic        tran_done = 0;
  logic        fifo_empty = 0;
  logic        fifo_incr, busy, op_done, cfg_err;

  mem_c_tile_addr_gen dut (
    .clk(clk), .reset(reset), .start_i(start_i), .m(m), .p(p), .ld_c(ld_c),
    .base_addr_c(base_addr_c), .do_tran(do_tran), .addr(addr), .lane_mask(lane_mask),
    .tran_done(tran_done), .fifo_empty(fifo_empty), .fifo_incr(fifo_incr),
    .busy(busy), .op_done(op_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int m; int p; int ld; logic [31:0] base; int beats; bit err; } vec_t;
  typedef struct { logic [31:0] a; logic [15:0] mk; } exp_t;

  int total = 0, bad = 0;
  exp_t exp_q[$];
  logic [31:0] wr_log[$];
  int incr_cnt, op_done_cnt, cfg_err_cnt, busy_cnt, rise_cnt, incr_at_done, mask_ff_cnt;
  logic prev_do = 0;
  logic [31:0] held_addr;
  int dcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Bus slave: tran_done asserted on the second edge after do_tran rises.
  always @(negedge clk) begin
    if (reset) begin
      dcnt = 0;
      tran_done = 0;
    end else if (do_tran && !tran_done) begin
      if (dcnt == 1) begin
        tran_done = 1;
        dcnt = 0;
      end else dcnt++;
    end else tran_done = 0;
  end

  always @(negedge clk) begin
    if (reset) prev_do = 0;
    else begin
      if (fifo_incr) incr_cnt++;
      if (busy) busy_cnt++;
      if (cfg_err) cfg_err_cnt++;
      if (op_done) begin
        op_done_cnt++;
        incr_at_done = incr_cnt;
      end
      if (do_tran && !prev_do) begin
        exp_t e;
        rise_cnt++;
        wr_log.push_back(addr);
        held_addr = addr;
        if (lane_mask == 16'h00FF) mask_ff_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%0h required=none", addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(addr), 64'(e.a));
          chk("wr_mask", 64'(lane_mask), 64'(e.mk));
        end
      end else if (do_tran) chk("addr_stable", 64'(addr), 64'(held_addr));
      prev_do = do_tran;
    end
  end

  task automatic push_model(input vec_t v, output int nw);
    nw = 0;
    for (int tr = 0; tr < v.m; tr += AH)
      for (int tc = 0; tc < v.p; tc += AW)
        for (int c = 0; c < AW; c += L)
          for (int r = 0; r < AH; r++) begin
            exp_t e;
            longint row = tr + r, col = tc + c;
            longint off = (row * v.ld + col) * DB;
`ifdef MEM_C_PARTIAL_TILE_EN
            e.mk = '0;
            for (int i = 0; i < L; i++) if (col + i < v.p) e.mk[i] = 1'b1;
            if (row >= v.m || e.mk == '0) continue;
`else
            e.mk = '1;
`endif
            e.a = v.base + off[31:0];
            exp_q.push_back(e);
            nw++;
          end
  endtask

  task automatic clear_mon();
    incr_cnt = 0; op_done_cnt = 0; cfg_err_cnt = 0; busy_cnt = 0;
    rise_cnt = 0; incr_at_done = -1; mask_ff_cnt = 0;
    wr_log.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input vec_t v);
    m = 16'(v.m); p = 16'(v.p); ld_c = 16'(v.ld); base_addr_c = v.base;
    start_i = 1;
    cyc();
    start_i = 0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 4000 && op_done_cnt == 0; k++) cyc();
    if (op_done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_op_done required=op_done", nm);
    end
    cyc();
    cyc();
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int nw = 0;
    clear_mon();
    exp_q.delete();
    if (!v.err) push_model(v, nw);
    pulse_start(v);
    wait_done(nm);
    chk({nm, "_incr"}, 64'(incr_cnt), 64'(v.beats));
    chk({nm, "_done"}, 64'(op_done_cnt), 64'd1);
    chk({nm, "_err"}, 64'(cfg_err_cnt), 64'(v.err ? 1 : 0));
    chk({nm, "_writes"}, 64'(wr_log.size()), 64'(nw));
    chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
    if (v.err) chk({nm, "_busy"}, 64'(busy_cnt), 64'd0);
    else chk({nm, "_done_after_last_incr"}, 64'(incr_at_done), 64'(v.beats));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [31:0] exp26[8];
    vec_t v;
    int t0;
    tbl[0] = '{4, 32, 32, 32'h1000, 8, 0};
    tbl[1] = '{8, 64, 80, 32'h2000, 32, 0};
    tbl[2] = '{4, 0, 32, 32'h1000, 0, 1};
    tbl[3] = '{4, 32, 16, 32'h1000, 0, 1};
    tbl[4] = '{0, 32, 32, 32'h1000, 0, 1};
`ifdef MEM_C_PARTIAL_TILE_EN
    tbl[5] = '{5, 40, 40, 32'h5000, 32, 0};
`else
    tbl[5] = '{5, 40, 40, 32'h5000, 0, 1};
`endif
    tbl[6] = '{4, 32, 32, 32'hFFFF_FFF0, 8, 0};
    tbl[7] = '{4, 32, 16'hFFE0, 32'h0, 8, 0};
    exp26 = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1020, 32'h1060, 32'h10A0, 32'h10E0};

    clear_mon();
    repeat (3) cyc();
    chk("rst_do_tran", 64'(do_tran), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_incr", 64'(fifo_incr), 64'd0);
    chk("rst_op_done", 64'(op_done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_mask", 64'(lane_mask), 64'hFFFF);
    reset = 0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
      if (i == 0)
        for (int j = 0; j < 8; j++)
          chk($sformatf("v0_addr%0d", j), 64'(wr_log.size() > j ? wr_log[j] : 32'hx), 64'(exp26[j]));
      if (i == 1)
        chk("tile_4_32", 64'(wr_log.size() > 24 ? wr_log[24] : 32'hx), 64'(32'h2000 + (4 * 80 + 32) * 2));
`ifdef MEM_C_PARTIAL_TILE_EN
      if (i == 5) chk("partial_col32_ff", 64'(mask_ff_cnt), 64'd5);
`endif
    end

    // Stall after the third pop, with a start_i attempt while busy.
    v = '{4, 32, 32, 32'h6000, 8, 0};
    clear_mon();
    exp_q.delete();
    begin
      int nw;
      push_model(v, nw);
    end
    pulse_start(v);
    for (int k = 0; k < 2000 && incr_cnt < 3; k++) cyc();
    chk("stall_reach", 64'(incr_cnt), 64'd3);
    fifo_empty = 1;
    t0 = rise_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        m = 16'd8; p = 16'd64; ld_c = 16'd64; base_addr_c = 32'h9000;
        start_i = 1;
      end else start_i = 0;
      cyc();
    end
    start_i = 0;
    chk("stall_no_tran", 64'(rise_cnt), 64'(t0));
    chk("stall_busy", 64'(busy), 64'd1);
    fifo_empty = 0;
    wait_done("stall");
    chk("stall_incr", 64'(incr_cnt), 64'd8);
    chk("stall_writes", 64'(wr_log.size()), 64'd8);
    chk("stall_leftover", 64'(exp_q.size()), 64'd0);
    chk("stall_err", 64'(cfg_err_cnt), 64'd0);
    chk("stall_done", 64'(op_done_cnt), 64'd1);

    // Reset while do_tran is high on the third beat.
    v = '{4, 32, 32, 32'h7000, 8, 0};
    clear_mon();
    exp_q.delete();
    begin
      int nw;
      push_model(v, nw);
    end
    pulse_start(v);
    for (int k = 0; k < 2000 && rise_cnt < 3; k++) cyc();
    chk("mid_do_tran", 64'(do_tran), 64'd1);
    reset = 1;
    t0 = op_done_cnt;
    cyc();
    chk("mid_rst_do_tran", 64'(do_tran), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_fifo_incr", 64'(fifo_incr), 64'd0);
    chk("mid_rst_op_done", 64'(op_done), 64'd0);
    chk("mid_rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("mid_rst_addr", 64'(addr), 64'd0);
    chk("mid_rst_mask", 64'(lane_mask), 64'hFFFF);
    reset = 0;
    exp_q.delete();
    repeat (5) cyc();
    chk("mid_rst_no_done", 64'(op_done_cnt), 64'(t0));
    chk("mid_rst_no_write", 64'(do_tran), 64'd0);
    run_op("restart", '{4, 32, 32, 32'h3000, 8, 0});
    chk("restart_first", 64'(wr_log.size() > 0 ? wr_log[0] : 32'hx), 64'h3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
